// File: rtl/wb_uart_rx_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and bus FSM states for the UART RX FIFO slave.
package wb_uart_rx_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_RSVD    = 2'd3;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_COUNT_LSB = 8;

   localparam int CTRL_CLR_OVERRUN = 0;
   localparam int CTRL_FLUSH       = 1;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_uart_rx_fifo.sv
// Synchronous FIFO with combinational head, flush and fill count; 1-cycle push-to-visible latency.
// Push while full is accepted only with a same-cycle pop; otherwise the caller sees it dropped.
module wb_uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              pop_ok;
   logic              push_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Flush overrides any same-cycle push or pop.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wishbone_uart_rx_fifo_slave.sv
// Wishbone classic slave exposing a UART RX FIFO as DATA/STATUS/CONTROL; ack one cycle after request.
// No bus stalls; RX characters arriving while full are dropped and flagged; WB_UART_RX_IRQ_EN adds irq_o.
import wb_uart_rx_pkg::*;

module wishbone_uart_rx_fifo_slave #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [31:0]       data_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   output logic [31:0]       data_o,
   output logic              ack_o,
   input  logic [DATA_W-1:0] rx_data_i,
   input  logic              rx_valid_i
`ifdef WB_UART_RX_IRQ_EN
   ,
   output logic              irq_o
`endif
);

   wb_state_t         state_q;
   wb_state_t         state_d;
   logic              req;
   logic              pop;
   logic              ctrl_wr;
   logic              flush;
   logic              clr_ovr;
   logic              ovr_set;
   logic              overrun_q;
   logic              full;
   logic              empty;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] head;
   logic [31:0]       rd_data;
   logic              unused_bits;

   assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:2]};

   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      case (state_q)
         IDLE: begin
            if (cyc_i && stb_i) begin
               state_d = ACK;
               req     = 1'b1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pop     = req && !we_i && (addr_i[3:2] == REG_DATA) && !empty;
   assign ctrl_wr = req && we_i && (addr_i[3:2] == REG_CONTROL);
   assign flush   = ctrl_wr && data_i[CTRL_FLUSH];
   assign clr_ovr = ctrl_wr && data_i[CTRL_CLR_OVERRUN];
   // A same-cycle pop makes room, and a flush discards the character anyway.
   assign ovr_set = rx_valid_i && full && !pop && !flush;

   always_comb begin
      rd_data = '0;
      if (!we_i) begin
         case (addr_i[3:2])
            REG_DATA: begin
               if (!empty) begin
                  rd_data[DATA_W-1:0] = head;
               end
            end
            REG_STATUS: begin
               rd_data[STAT_NOT_EMPTY]            = !empty;
               rd_data[STAT_FULL]                 = full;
               rd_data[STAT_OVERRUN]              = overrun_q;
               rd_data[STAT_COUNT_LSB +: CNT_W]   = count;
            end
            REG_CONTROL, REG_RSVD: rd_data = '0;
            default:               rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         data_o    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req) begin
            data_o <= rd_data;
         end
         if (ovr_set) begin
            overrun_q <= 1'b1;
         end else if (clr_ovr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign ack_o = (state_q == ACK);

`ifdef WB_UART_RX_IRQ_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= !empty || overrun_q;
      end
   end
`endif

   wb_uart_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (rx_valid_i),
      .push_dat (rx_data_i),
      .pop      (pop),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .head     (head)
   );

endmodule

// File: tb/tb_wishbone_uart_rx_fifo_slave.sv
// Directed bench for the UART RX FIFO Wishbone slave: vector table plus hand-written corner sequences.
module tb_wishbone_uart_rx_fifo_slave;
   import wb_uart_rx_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [31:0]       addr_i;
   logic              we_i;
   logic [31:0]       data_i;
   logic              cyc_i;
   logic              stb_i;
   logic [31:0]       data_o;
   logic              ack_o;
   logic [DATA_W-1:0] rx_data_i;
   logic              rx_valid_i;
`ifdef WB_UART_RX_IRQ_EN
   logic              irq_o;
`endif

   always #5 clk_i = ~clk_i;

   wishbone_uart_rx_fifo_slave #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .addr_i     (addr_i),
      .we_i       (we_i),
      .data_i     (data_i),
      .cyc_i      (cyc_i),
      .stb_i      (stb_i),
      .data_o     (data_o),
      .ack_o      (ack_o),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i)
`ifdef WB_UART_RX_IRQ_EN
      ,
      .irq_o      (irq_o)
`endif
   );

   typedef enum int { OP_PUSH, OP_READ, OP_WRITE } op_t;

   typedef struct {
      op_t         op;
      logic [1:0]  rsel;
      logic [31:0] wdat;
      bit          push;
      logic [7:0]  ch;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void v_push(input logic [7:0] c);
      vec_t v;
      v.op = OP_PUSH; v.rsel = 2'd0; v.wdat = '0; v.push = 1'b1; v.ch = c; v.exp = '0;
      vecs.push_back(v);
   endfunction

   function automatic void v_read(input logic [1:0] r, input logic [31:0] e,
                                  input bit p = 1'b0, input logic [7:0] c = 8'h00);
      vec_t v;
      v.op = OP_READ; v.rsel = r; v.wdat = '0; v.push = p; v.ch = c; v.exp = e;
      vecs.push_back(v);
   endfunction

   function automatic void v_write(input logic [1:0] r, input logic [31:0] w,
                                   input bit p = 1'b0, input logic [7:0] c = 8'h00);
      vec_t v;
      v.op = OP_WRITE; v.rsel = r; v.wdat = w; v.push = p; v.ch = c; v.exp = '0;
      vecs.push_back(v);
   endfunction

   function automatic logic [31:0] stat(input int cnt, input bit ovr);
      logic [31:0] s;
      s = '0;
      s[0] = (cnt != 0);
      s[1] = (cnt == DEPTH);
      s[2] = ovr;
      s[8 +: CNT_W] = CNT_W'(cnt);
      return s;
   endfunction

   task automatic do_push(input logic [7:0] c);
      rx_valid_i = 1'b1;
      rx_data_i  = c;
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
   endtask

   // Single access, optionally with a coincident RX strobe in the request cycle.
   task automatic wb_access(input string name, input bit we, input logic [1:0] r,
                            input logic [31:0] wd, input bit p, input logic [7:0] c,
                            output logic [31:0] rd);
      cyc_i  = 1'b1;
      stb_i  = 1'b1;
      we_i   = we;
      addr_i = {28'h0, r, 2'b00};
      data_i = wd;
      rx_valid_i = p;
      rx_data_i  = c;
      @(posedge clk_i); #1;
      cyc_i = 1'b0;
      stb_i = 1'b0;
      we_i  = 1'b0;
      rx_valid_i = 1'b0;
      check({name, " ack"}, {31'h0, ack_o}, 32'h1);
      rd = data_o;
      @(posedge clk_i); #1;
      check({name, " ack_drop"}, {31'h0, ack_o}, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] acks;
      logic [31:0] rdat [2];

      rst_i = 1'b1; addr_i = '0; we_i = 1'b0; data_i = '0;
      cyc_i = 1'b0; stb_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;

      // Empty, then three characters in order
      v_read(REG_STATUS, 32'h0);
      v_read(REG_DATA, 32'h0);
      v_read(REG_STATUS, 32'h0);
      v_push(8'h41); v_push(8'h42); v_push(8'h43);
      v_read(REG_STATUS, stat(3, 0));
      v_read(REG_DATA, 32'h41);
      v_read(REG_DATA, 32'h42);
      v_read(REG_DATA, 32'h43);
      v_read(REG_STATUS, 32'h0);
      // Overrun: DEPTH+1 pushes, drain, then clear
      for (int i = 0; i <= DEPTH; i++) v_push(8'(i));
      v_read(REG_STATUS, 32'h0000_1007);
      for (int i = 0; i < DEPTH; i++) v_read(REG_DATA, 32'(i));
      v_read(REG_STATUS, stat(0, 1));
      v_write(REG_CONTROL, 32'h1);
      v_read(REG_STATUS, 32'h0);
      // Full with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) v_push(8'hA0 + 8'(i));
      v_read(REG_DATA, 32'hA0, 1'b1, 8'h55);
      v_read(REG_STATUS, 32'h0000_1003);
      for (int i = 1; i < DEPTH; i++) v_read(REG_DATA, 32'hA0 + 32'(i));
      v_read(REG_DATA, 32'h55);
      v_read(REG_STATUS, 32'h0);
      // Clear-overrun coinciding with a new overrun; then flush+clear together
      for (int i = 0; i < DEPTH; i++) v_push(8'hB0 + 8'(i));
      v_write(REG_CONTROL, 32'h1, 1'b1, 8'hEE);
      v_read(REG_STATUS, 32'h0000_1007);
      v_write(REG_CONTROL, 32'h3);
      v_read(REG_STATUS, 32'h0);
      // Ignored writes, zero reads, and flush with coincident push
      v_write(REG_DATA, 32'h99);
      v_read(REG_STATUS, 32'h0);
      v_push(8'h11); v_push(8'h22); v_push(8'h33);
      v_write(REG_STATUS, 32'hFFFF_FFFF);
      v_write(REG_RSVD, 32'hFFFF_FFFF);
      v_read(REG_STATUS, stat(3, 0));
      v_read(REG_RSVD, 32'h0);
      v_read(REG_CONTROL, 32'h0);
      v_write(REG_CONTROL, 32'h2, 1'b1, 8'h44);
      v_read(REG_STATUS, 32'h0);
      v_read(REG_DATA, 32'h0);
      // DATA read while empty with a coincident push: returns 0, char kept
      v_read(REG_DATA, 32'h0, 1'b1, 8'h66);
      v_read(REG_STATUS, stat(1, 0));
      v_read(REG_DATA, 32'h66);

      repeat (3) @(posedge clk_i);
      #1;
      check("reset ack_o", {31'h0, ack_o}, 32'h0);
      check("reset data_o", data_o, 32'h0);
`ifdef WB_UART_RX_IRQ_EN
      check("reset irq_o", {31'h0, irq_o}, 32'h0);
`endif
      rst_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_PUSH: do_push(vecs[i].ch);
            OP_READ: begin
               wb_access($sformatf("vec%0d", i), 1'b0, vecs[i].rsel, 32'h0,
                         vecs[i].push, vecs[i].ch, rd);
               check($sformatf("vec%0d data", i), rd, vecs[i].exp);
            end
            default: wb_access($sformatf("vec%0d", i), 1'b1, vecs[i].rsel, vecs[i].wdat,
                               vecs[i].push, vecs[i].ch, rd);
         endcase
      end

      // Strobe held high: one access per two cycles
      do_push(8'h61);
      do_push(8'h62);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = {28'h0, REG_DATA, 2'b00};
      acks = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i); #1;
         acks[k] = ack_o;
         if (k == 0) rdat[0] = data_o;
         if (k == 2) rdat[1] = data_o;
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      check("b2b ack pattern", acks, 32'h5);
      check("b2b first", rdat[0], 32'h61);
      check("b2b second", rdat[1], 32'h62);
      wb_access("b2b status", 1'b0, REG_STATUS, 32'h0, 1'b0, 8'h0, rd);
      check("b2b status data", rd, 32'h0);

`ifdef WB_UART_RX_IRQ_EN
      rx_valid_i = 1'b1; rx_data_i = 8'h5A;
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
      check("irq same edge", {31'h0, irq_o}, 32'h0);
      @(posedge clk_i); #1;
      check("irq after push", {31'h0, irq_o}, 32'h1);
      wb_access("irq pop", 1'b0, REG_DATA, 32'h0, 1'b0, 8'h0, rd);
      check("irq pop data", rd, 32'h5A);
      check("irq after pop", {31'h0, irq_o}, 32'h0);
`endif

      // Reset asserted while in ACK
      do_push(8'h77);
      do_push(8'h78);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = {28'h0, REG_DATA, 2'b00};
      @(posedge clk_i); #1;
      cyc_i = 1'b0; stb_i = 1'b0;
      check("rst-in-ack ack", {31'h0, ack_o}, 32'h1);
      check("rst-in-ack data", data_o, 32'h77);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("rst-in-ack ack drop", {31'h0, ack_o}, 32'h0);
      check("rst-in-ack data_o", data_o, 32'h0);
`ifdef WB_UART_RX_IRQ_EN
      check("rst-in-ack irq", {31'h0, irq_o}, 32'h0);
`endif
      rst_i = 1'b0;
      wb_access("post-rst status", 1'b0, REG_STATUS, 32'h0, 1'b0, 8'h0, rd);
      check("post-rst status data", rd, 32'h0);
      wb_access("post-rst data", 1'b0, REG_DATA, 32'h0, 1'b0, 8'h0, rd);
      check("post-rst data data", rd, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wishbone_uart_rx_fifo_slave.md
# wishbone_uart_rx_fifo_slave

Parametrised Wishbone classic slave that buffers characters from the UART receiver in a FIFO and exposes them via a small register map (DATA, STATUS, CONTROL). It sits between the UART RX deserialiser and the Wishbone interconnect and replaces the single-character unbuffered RX slave. It adds buffering, overrun detection, a fill-level report and a flush control. An optional interrupt output can be compiled in.

## Interface
- `DATA_W`, 8: received character width, 5..9 bits.
- `DEPTH`, 16: FIFO entries, power of two, 2..256.
- `CNT_W`, `$clog2(DEPTH)+1`: fill-count width (derived, not overridden).

- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `addr_i` in 32: byte address; only `[3:2]` decoded (select is done externally through cyc/stb).
- `we_i` in 1: write enable.
- `data_i` in 32: write data (CONTROL only).
- `cyc_i` in 1: bus cycle.
- `stb_i` in 1: strobe.
- `data_o` out 32: read data; valid while `ack_o`=1.
- `ack_o` out 1: one-cycle acknowledge.
- `rx_data_i` in DATA_W: character from the UART receiver.
- `rx_valid_i` in 1: one-cycle strobe, `rx_data_i` valid.
- `irq_o` out 1: interrupt (only with WB_UART_RX_IRQ_EN).

## Operation
- Register map, selected by `addr_i[3:2]`:
  - 0 DATA (R): `{zero-pad, head char}`. Popping happens on the ack. When the FIFO is empty, returns 0 and does not pop.
  - 1 STATUS (R): bit0 not_empty, bit1 full, bit2 overrun (sticky), bits `[8+CNT_W-1:8]` count.
  - 2 CONTROL (W): bit0=1 clears overrun, bit1=1 flushes the FIFO. Reads return 0.
  - 3: reserved. Reads return 0, writes are ignored.
- Every access is acked, including writes to read-only or reserved registers (those writes are ignored). No err/retry.
- Two-state FSM:
  - IDLE --(cyc_i & stb_i)--> ACK.
  - ACK --> IDLE unconditionally.
- On the IDLE→ACK edge:
  - `data_o` is registered.
  - A pop is performed for a DATA read.
  - A CONTROL write is applied.
- Push: on `rx_valid_i` and not full, the character is written and count+1.
- Full + `rx_valid_i` without a same-cycle pop: the character is dropped and overrun is set.
- Simultaneous push and pop: both take effect and count is unchanged. This applies when full as well; in that case there is no overrun.
- Flush + push in the same cycle: flush wins, the pushed character is discarded, count=0, and overrun is not set.
- Clear-overrun + a new overrun event in the same cycle: overrun ends up set.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Count saturates neither way; full is defined as count==DEPTH.

## Timing
- Reset values (all outputs and internal state):
  - `ack_o`=0, `data_o`=0, `irq_o`=0.
  - FSM=IDLE.
  - Pointers and count=0, overrun=0.
- Request sampled in cycle N → `ack_o`=1 and `data_o` valid in N+1 → `ack_o`=0 in N+2.
- Fill-level effects:
  - Pop is visible in STATUS from N+1 onward.
  - A push in cycle M is visible in STATUS read data sampled in M+1.
- If the master holds stb high, the next access is sampled in N+2, giving at most one access per 2 cycles.
- `data_o` holds its last value when `ack_o`=0. Masters must not rely on that value.
- Reset asserted in ACK: `ack_o` drops the next cycle. Any pop or write already applied stands; the FIFO is then cleared by reset.

## Configuration
- `WB_UART_RX_IRQ_EN`:
  - Defined: the `irq_o` port exists and is registered, `irq_o` = not_empty | overrun. It updates one cycle after the underlying state changes and is 0 in reset.
  - Undefined: the `irq_o` port and its logic are absent. The register map is unchanged.

## Structure
- Package `wb_uart_rx_pkg` holds:
  - Register offset constants (DATA/STATUS/CONTROL/RSVD).
  - STATUS and CONTROL bit positions.
  - The FSM state enum (IDLE, ACK).
- Sub-module `wb_uart_rx_fifo` is a synchronous FIFO (parameters DATA_W, DEPTH) with push, pop, flush, full, empty, count and head. It is combinational-read at the head.
- The top level contains only the FSM, the address decode, overrun and irq.

## Test plan
- Reset, then read STATUS → `data_o`=0x0000_0000. Read DATA → 0, and count stays 0.
- Push 0x41, 0x42, 0x43, read DATA three times → 0x41, 0x42, 0x43. Then STATUS → 0 (empty).
- Push DEPTH+1 characters (0x00..0x10 with DEPTH=16) → STATUS full=1, overrun=1, count=16. Draining returns 0x00..0x0F. Writing CONTROL=0x1 clears overrun.
- Fill to full, then push 0x55 in the same cycle as a DATA pop → no overrun, count stays 16, and 0x55 is the last character out.
- Partial fill, CONTROL=0x2 with coincident `rx_valid_i` → count=0, the pushed character is lost, overrun=0.
- With `WB_UART_RX_IRQ_EN` defined: push 1 character → `irq_o`=1 one cycle later. Pop it → `irq_o`=0. Assert `rst_i` during ACK → `ack_o`=0 next cycle and all state is reset.
